// File: rtl/sdf_delay_line.sv
// Complex-sample delay line for radix-2 SDF FFT feedback paths. The active depth
// can be changed at run time, entries carry valid tags, and the line drains itself.

module sdf_delay_stage #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!reset)
            q <= '0;
        else if (shift)
            q <= d;
    end
endmodule

module sdf_delay_line #(
    parameter int DATA_W  = 24,
    parameter int DEPTH   = 16,
    parameter int DEPTH_W = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] din_r,
    input  logic signed [DATA_W-1:0] din_i,
    input  logic                     flush,
    input  logic        [DEPTH_W-1:0] depth_sel,
    output logic signed [DATA_W-1:0] dout_r,
    output logic signed [DATA_W-1:0] dout_i,
    output logic                     out_valid,
    output logic        [DEPTH_W-1:0] occupancy,
    output logic                     empty,
    output logic                     full
);
    localparam int SW = 2 * DATA_W;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } sample_t;

    sample_t [DEPTH-1:0] stage_d;
    sample_t [DEPTH-1:0] stage_q;
    logic    [DEPTH-1:0] vld_pipe;

    logic [DEPTH_W-1:0] active_depth;
    logic [DEPTH_W-1:0] occ;
    logic [DEPTH_W-1:0] depth_clamped;
    sample_t            tail;
    logic               tail_vld;
    logic               idle;
    logic               shift;

    assign idle  = (occ == '0) && !in_valid;
    assign shift = !flush && (in_valid || (occ != '0));

    always_comb begin
        depth_clamped = depth_sel;
        if (depth_sel == '0 || depth_sel > DEPTH_W'(DEPTH))
            depth_clamped = DEPTH_W'(DEPTH);
    end

    // Bubbles enter as zeros so a gap reads as a clean zero sample at the tail.
    assign stage_d[0] = in_valid ? sample_t'{re: din_r, im: din_i} : sample_t'('0);

    genvar k;
    generate
        for (k = 1; k < DEPTH; k++) begin : g_link
            assign stage_d[k] = stage_q[k-1];
        end
        for (k = 0; k < DEPTH; k++) begin : g_stage
            sdf_delay_stage #(.W(SW)) u_stage (
                .clk   (clk),
                .reset (reset),
                .shift (shift),
                .d     (stage_d[k]),
                .q     (stage_q[k])
            );
        end
    endgenerate

    always_comb begin
        tail     = '0;
        tail_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (active_depth == DEPTH_W'(i + 1)) begin
                tail     = stage_q[i];
                tail_vld = vld_pipe[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_pipe     <= '0;
            occ          <= '0;
            active_depth <= DEPTH_W'(DEPTH);
        end else begin
            if (flush || idle)
                active_depth <= depth_clamped;
            // On idle edges the active window holds no tags, so clearing the whole
            // pipe only drops tags that drifted past the tail; a later, deeper
            // setting can then never resurrect them as phantom outputs.
            if (flush || idle)
                vld_pipe <= '0;
            else if (shift)
                vld_pipe <= (vld_pipe << 1) | DEPTH'(in_valid);
            if (flush)
                occ <= '0;
            else if (shift)
                occ <= occ + DEPTH_W'(in_valid) - DEPTH_W'(tail_vld);
        end
    end

    assign dout_r    = tail.re;
    assign dout_i    = tail.im;
    assign out_valid = tail_vld;
    assign occupancy = occ;
    assign empty     = (occ == '0);
    assign full      = (occ == active_depth);
endmodule

// File: tb/tb_sdf_delay_line.sv
// Directed bench for sdf_delay_line: streams, gaps, depth changes, flush, reset.

module tb_sdf_delay_line;
    localparam int DW    = 24;
    localparam int DEPTH = 16;
    localparam int DSW   = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic signed [DW-1:0] din_r, din_i;
    logic                 flush;
    logic [DSW-1:0]       depth_sel;
    logic signed [DW-1:0] dout_r, dout_i;
    logic                 out_valid;
    logic [DSW-1:0]       occupancy;
    logic                 empty, full;

    int n_chk  = 0;
    int n_pass = 0;

    int g_in [0:3] = '{5, 0, 6, 7};
    int g_v  [0:3] = '{1, 0, 1, 1};
    int e_v  [0:8] = '{0, 0, 0, 1, 0, 1, 1, 0, 0};
    int e_d  [0:8] = '{0, 0, 0, 5, 0, 6, 7, 0, 0};
    int e_o  [0:8] = '{1, 1, 2, 3, 2, 2, 1, 0, 0};

    sdf_delay_line #(.DATA_W(DW), .DEPTH(DEPTH), .DEPTH_W(DSW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .din_r     (din_r),
        .din_i     (din_i),
        .flush     (flush),
        .depth_sel (depth_sel),
        .dout_r    (dout_r),
        .dout_i    (dout_i),
        .out_valid (out_valid),
        .occupancy (occupancy),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got %0d exp %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Contiguous burst of n samples base+c / -(base+c); checks every cycle
    // against the closed-form arrival time and occupancy for depth d.
    task automatic run_stream(input int d, input int n, input int base, input int ncyc,
                              input int chg_at, input int chg_val);
        for (int c = 0; c < ncyc; c++) begin
            int s, acc, ex, oe;
            bit ve;
            if (c == chg_at) depth_sel = DSW'(chg_val);
            in_valid = (c < n);
            din_r    = (c < n) ? DW'(base + c)    : '0;
            din_i    = (c < n) ? DW'(-(base + c)) : '0;
            step();
            s   = c - d + 1;
            ve  = (s >= 0) && (s < n);
            acc = (c + 1 < n) ? c + 1 : n;
            ex  = (c - d + 1 < 0) ? 0 : ((c - d + 1 > n) ? n : c - d + 1);
            oe  = acc - ex;
            chk("out_valid", out_valid, ve);
            if (ve) begin
                chk("dout_r", dout_r, base + s);
                chk("dout_i", dout_i, -(base + s));
            end
            chk("occupancy", occupancy, oe);
            chk("full", full, oe == d);
            chk("empty", empty, oe == 0);
        end
        in_valid = 1'b0;
        din_r    = '0;
        din_i    = '0;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; din_r = '0; din_i = '0;
        flush = 1'b0; depth_sel = DSW'(16);
        step(); step();
        chk("rst_dout_r", dout_r, 0);
        chk("rst_dout_i", dout_i, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        reset = 1'b1;
        step();

        // 32-sample stream at D=16
        run_stream(16, 32, 0, 50, -1, 0);

        // gapped input at D=4
        depth_sel = DSW'(4);
        step();
        for (int c = 0; c < 9; c++) begin
            in_valid = (c < 4) ? g_v[c][0] : 1'b0;
            din_r    = (c < 4) ? DW'(g_in[c])    : '0;
            din_i    = (c < 4) ? DW'(-g_in[c])   : '0;
            step();
            chk("gap_valid", out_valid, e_v[c]);
            chk("gap_dout_r", dout_r, e_d[c]);
            chk("gap_dout_i", dout_i, -e_d[c]);
            chk("gap_occ", occupancy, e_o[c]);
        end
        in_valid = 1'b0;

        // mid-stream depth_sel change has no effect, then switch to 8 after drain
        depth_sel = DSW'(16);
        step();
        run_stream(16, 4, 40, 22, 2, 4);
        depth_sel = DSW'(8);
        step();
        run_stream(8, 8, 60, 18, -1, 0);

        // flush at occupancy 10 with a colliding input
        depth_sel = DSW'(16);
        step();
        run_stream(16, 10, 100, 10, -1, 0);
        flush = 1'b1; in_valid = 1'b1; din_r = DW'(99); din_i = DW'(-99);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_occ", occupancy, 0);
        chk("flush_empty", empty, 1);
        chk("flush_valid", out_valid, 0);
        for (int c = 0; c < 20; c++) begin
            step();
            chk("post_flush_valid", out_valid, 0);
            chk("post_flush_occ", occupancy, 0);
        end

        // out-of-range depth_sel loads DEPTH; then D=1
        depth_sel = DSW'(0);
        step();
        run_stream(16, 1, 3, 18, -1, 0);
        depth_sel = DSW'(DEPTH + 3);
        step();
        run_stream(16, 1, 4, 18, -1, 0);
        depth_sel = DSW'(1);
        step();
        run_stream(1, 3, 7, 5, -1, 0);

        // reset with occupancy 12; depth returns to DEPTH
        depth_sel = DSW'(16);
        step();
        run_stream(16, 12, 300, 12, -1, 0);
        reset = 1'b0;
        step();
        chk("mrst_dout_r", dout_r, 0);
        chk("mrst_dout_i", dout_i, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_occ", occupancy, 0);
        chk("mrst_empty", empty, 1);
        chk("mrst_full", full, 0);
        reset = 1'b1;
        depth_sel = DSW'(4);
        run_stream(16, 2, 500, 19, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
